// File: rtl/fl_fifo_status_pkg.sv
// fl_fifo_status_pkg: shared types, width helper and parameter legality for the FIFO status unit.
package fl_fifo_status_pkg;
  typedef enum logic [1:0] {HOLD, INC, DEC} cnt_op_e;
  function automatic int free_w(input int items);
    return $clog2(items) + 1;
  endfunction
  function automatic bit params_ok(input int items, input int status_width, input int block_size);
    return items >= 4 && (items & (items - 1)) == 0 &&
           status_width >= 1 && status_width <= free_w(items) &&
           block_size >= 1 && block_size < items;
  endfunction
endpackage

// File: rtl/fl_fifo_status_if.sv
// fl_fifo_status_if: FIFO strobes from the datapath and the status flags returned to it.
interface fl_fifo_status_if #(parameter int STATUS_WIDTH = 8);
  logic                    wr;
  logic                    wr_eof;
  logic                    rd;
  logic                    rd_eof;
  logic                    lstblk;
  logic [STATUS_WIDTH-1:0] status;
  logic                    empty;
  logic                    full;
  logic                    frame_rdy;
  logic                    err;
  modport master(output wr, wr_eof, rd, rd_eof, input lstblk, status, empty, full, frame_rdy, err);
  modport slave(input wr, wr_eof, rd, rd_eof, output lstblk, status, empty, full, frame_rdy, err);
endinterface

// File: rtl/fl_updown_cnt.sv
// fl_updown_cnt: saturating up/down counter (0..MAX) that flags decrement attempts at zero.
module fl_updown_cnt
  import fl_fifo_status_pkg::*;
#(
  parameter int MAX   = 16,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  cnt_op_e          op_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_nxt_o,
  output logic             udf_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_max, at_zero;
  assign at_max    = cnt_q == WIDTH'(MAX);
  assign at_zero   = cnt_q == '0;
  assign cnt_d     = (op_i == INC && !at_max) ? cnt_q + 1'b1 :
                     (op_i == DEC && !at_zero) ? cnt_q - 1'b1 : cnt_q;
  assign udf_o     = op_i == DEC && at_zero;
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fl_fifo_status_unit.sv
// fl_fifo_status_unit: item/frame bookkeeping producing registered FrameLink FIFO status flags.
module fl_fifo_status_unit
  import fl_fifo_status_pkg::*;
#(
  parameter int ITEMS        = 512,
  parameter int STATUS_WIDTH = 8,
  parameter int BLOCK_SIZE   = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  fl_fifo_status_if.slave bus
);
  localparam int FREE_W = free_w(ITEMS);
  localparam logic [FREE_W-1:0] ITEMS_W = FREE_W'(ITEMS);
  if (!params_ok(ITEMS, STATUS_WIDTH, BLOCK_SIZE)) begin : g_bad_params
    $error("fl_fifo_status_unit: illegal ITEMS/STATUS_WIDTH/BLOCK_SIZE");
  end
  logic                    wa, ra, fw, fr;
  cnt_op_e                 item_op, frm_op;
  logic [FREE_W-1:0]       items_cnt, items_nxt, frm_cnt, frm_nxt, free_d;
  logic                    items_udf, frm_udf;
  logic                    lstblk_q, empty_q, full_q, frame_rdy_q, err_q;
  logic [STATUS_WIDTH-1:0] status_q;
  logic                    unused_ok;
  // Acceptance is gated by the registered flags so the counts can never leave 0..ITEMS.
  assign wa      = bus.wr & ~full_q;
  assign ra      = bus.rd & ~empty_q;
  assign fw      = wa & bus.wr_eof;
  assign fr      = ra & bus.rd_eof;
  assign item_op = (wa & ~ra) ? INC : (ra & ~wa) ? DEC : HOLD;
  assign frm_op  = (fw & ~fr) ? INC : (fr & ~fw) ? DEC : HOLD;
  fl_updown_cnt #(.MAX(ITEMS), .WIDTH(FREE_W)) u_items (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .op_i     (item_op),
    .cnt_o    (items_cnt),
    .cnt_nxt_o(items_nxt),
    .udf_o    (items_udf)
  );
  fl_updown_cnt #(.MAX(ITEMS), .WIDTH(FREE_W)) u_frames (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .op_i     (frm_op),
    .cnt_o    (frm_cnt),
    .cnt_nxt_o(frm_nxt),
    .udf_o    (frm_udf)
  );
  assign unused_ok = ^{items_cnt, frm_cnt, items_udf};
  assign free_d    = ITEMS_W - items_nxt;
  // Flags are derived from next-state counts so they line up with the stored counts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lstblk_q    <= 1'b0;
      status_q    <= ITEMS_W[FREE_W-1 -: STATUS_WIDTH];
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lstblk_q    <= free_d <= FREE_W'(BLOCK_SIZE);
      status_q    <= free_d[FREE_W-1 -: STATUS_WIDTH];
      empty_q     <= items_nxt == '0;
      full_q      <= items_nxt == ITEMS_W;
      frame_rdy_q <= frm_nxt != '0;
      err_q       <= err_q | frm_udf;
    end
  end
  assign bus.lstblk    = lstblk_q;
  assign bus.status    = status_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.frame_rdy = frame_rdy_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_fl_fifo_status_unit.sv
// tb_fl_fifo_status_unit: directed sequence against a reference occupancy/frame model via a scoreboard queue.
module tb_fl_fifo_status_unit;
  localparam int ITEMS = 16;
  localparam int SW    = 3;
  localparam int BS    = 4;
  localparam int FW    = 5;
  typedef struct packed {
    logic          lstblk;
    logic [SW-1:0] status;
    logic          empty;
    logic          full;
    logic          frame_rdy;
    logic          err;
  } flags_t;
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  flags_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     m_used = 0;
  int     m_frm = 0;
  logic   m_err = 1'b0;
  always #5 clk = ~clk;
  fl_fifo_status_if #(.STATUS_WIDTH(SW)) bus ();
  fl_fifo_status_unit #(.ITEMS(ITEMS), .STATUS_WIDTH(SW), .BLOCK_SIZE(BS)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );
  task automatic step(input string nm, input logic w, input logic we, input logic r, input logic re, input logic rn);
    logic   wa, ra;
    flags_t e, o;
    bus.wr = w;
    bus.wr_eof = we;
    bus.rd = r;
    bus.rd_eof = re;
    rst_n = rn;
    if (!rn) begin
      m_used = 0;
      m_frm = 0;
      m_err = 1'b0;
    end else begin
      wa = w && m_used < ITEMS;
      ra = r && m_used > 0;
      m_used = m_used + int'(wa) - int'(ra);
      if (wa && we && !(ra && re)) m_frm++;
      else if (ra && re && !(wa && we)) begin
        if (m_frm == 0) m_err = 1'b1;
        else m_frm--;
      end
    end
    e.lstblk = (ITEMS - m_used) <= BS;
    e.status = SW'((ITEMS - m_used) >> (FW - SW));
    e.empty = m_used == 0;
    e.full = m_used == ITEMS;
    e.frame_rdy = m_frm > 0;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    o = '{bus.lstblk, bus.status, bus.empty, bus.full, bus.frame_rdy, bus.err};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed lstblk/status/empty/full/frame_rdy/err=%b/%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b/%b",
             nm, o.lstblk, o.status, o.empty, o.full, o.frame_rdy, o.err,
             e.lstblk, e.status, e.empty, e.full, e.frame_rdy, e.err);
    end
  endtask
  initial begin
    bus.wr = 1'b0;
    bus.wr_eof = 1'b0;
    bus.rd = 1'b0;
    bus.rd_eof = 1'b0;
    step("reset0", 1, 0, 1, 0, 0);
    step("reset1", 1, 0, 1, 0, 0);
    for (int i = 0; i < 18; i++) step($sformatf("fill%0d", i), 1, 0, 0, 0, 1);
    step("sim_full", 1, 0, 1, 0, 1);
    step("sim_full2", 1, 0, 1, 0, 1);
    for (int i = 0; i < 15; i++) step($sformatf("drain%0d", i), 0, 0, 1, 0, 1);
    step("rdeof_empty", 0, 0, 1, 1, 1);
    step("sim_empty", 1, 0, 1, 0, 1);
    step("drain_last", 0, 0, 1, 0, 1);
    step("frm_w0", 1, 0, 0, 0, 1);
    step("frm_w1", 1, 0, 0, 0, 1);
    step("frm_w2_eof", 1, 1, 0, 0, 1);
    step("frm_r0", 0, 0, 1, 0, 1);
    step("frm_r1", 0, 0, 1, 0, 1);
    step("frm_r2_eof", 0, 0, 1, 1, 1);
    step("udf_w0", 1, 0, 0, 0, 1);
    step("udf_w1", 1, 0, 0, 0, 1);
    step("udf_r_eof", 0, 0, 1, 1, 1);
    step("err_hold0", 0, 0, 0, 0, 1);
    step("err_hold1", 1, 1, 0, 0, 1);
    step("err_hold2", 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step($sformatf("load%0d", i), 1, (i == 3 || i == 7), 0, 0, 1);
    step("mid_reset", 1, 1, 1, 1, 0);
    step("post_reset_wr", 1, 0, 0, 0, 1);
    step("post_reset_idle", 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fl_fifo_status_unit.md
# fl_fifo_status_unit

Bookkeeping stage that generates the FrameLink FIFO control/status signals (LSTBLK, STATUS, EMPTY, FULL, FRAME_RDY) from the FIFO's write and read strobes. It sits directly upstream of the FIFO control interface and drives every one of its outputs. It tracks an item occupancy count and a complete-frame count, both registered. The FIFO memory itself remains in the FIFO datapath.

## Interface
- ITEMS, 512, FIFO depth in items; power of two, ≥ 4.
- STATUS_WIDTH, 8, width of STATUS; must be ≤ FREE_W = log2(ITEMS)+1.
- BLOCK_SIZE, 16, LSTBLK threshold in items; 1 ≤ BLOCK_SIZE < ITEMS.
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low (0 = reset).
- WR  in  1  write request from the datapath.
- WR_EOF  in  1  item being written is the last item of a frame; valid with WR.
- RD  in  1  read request from the datapath.
- RD_EOF  in  1  item being read is the last item of a frame; valid with RD.
- LSTBLK  out  1  free items ≤ BLOCK_SIZE.
- STATUS  out  STATUS_WIDTH  free[FREE_W-1 : FREE_W-STATUS_WIDTH], the MSBs of the free-item count.
- EMPTY  out  1  used count = 0.
- FULL  out  1  used count = ITEMS.
- FRAME_RDY  out  1  frame count > 0.
- ERR  out  1  sticky; a frame-count underflow was attempted.

## Operation
- Accepted write: `wa = WR & ~FULL`. A write while FULL is ignored with no state change.
- Accepted read: `ra = RD & ~EMPTY`. A read while EMPTY is ignored.
- Used count (FREE_W bits) is updated every cycle:
  - +1 on wa only.
  - −1 on ra only.
  - Unchanged on both or neither.
  - Range 0..ITEMS; the count never wraps.
- Free count = ITEMS − used.
- Frame count (FREE_W bits) is updated every cycle:
  - +1 when `wa & WR_EOF`; −1 when `ra & RD_EOF`.
  - Unchanged when both occur together, or neither.
  - Underflow case: `ra & RD_EOF & ~(wa & WR_EOF)` while the frame count is 0.
    - The count stays at 0.
    - ERR is set and stays set until reset.
    - The item count still decrements normally.
- WR_EOF and RD_EOF are ignored when their strobe is not accepted.
- All outputs are registered and computed from the next-state counts, so they always match the stored counts.
- Reset (RESET = 0 on a rising edge):
  - Both counts go to 0.
  - EMPTY = 1, FULL = 0, FRAME_RDY = 0, ERR = 0.
  - STATUS = MSBs of ITEMS.
  - LSTBLK = 0.
  - Reset overrides any same-cycle WR/RD.
  - Reset asserted mid-operation discards all counts; no partial state survives.
- No FSM. State consists of the two counters plus ERR.

## Timing
- Latency is one edge. A strobe sampled at edge t is reflected in all outputs right after edge t.
- FULL and EMPTY gate acceptance combinationally in the same cycle, using their registered values.
- Simultaneous accepted WR and RD at full:
  - RD is accepted; WR is not (FULL = 1).
  - Result: used = ITEMS − 1, FULL deasserts.
- Simultaneous accepted WR and RD at empty:
  - WR is accepted; RD is not (EMPTY = 1).
  - Result: used = 1.
- The first cycle after reset deassertion already accepts WR.

## Structure
- Package `fl_fifo_status_pkg` holds:
  - function `free_w(items)`, returning log2(items)+1;
  - an enum for counter operation {HOLD, INC, DEC};
  - the parameter-legality checks (elaboration-time assertions).
- Sub-module `fl_updown_cnt`: a saturating up/down counter with parameters MAX and WIDTH.
  - Inputs: op, rst_n.
  - Outputs: cnt, cnt_nxt, underflow attempt.
  - Instantiated twice: once for items, once for frames.
- Top level holds the acceptance gating, the output registers and ERR.

## Test plan
Parameters for all scenarios: ITEMS = 16, STATUS_WIDTH = 3, BLOCK_SIZE = 4 (FREE_W = 5).
- Reset check: hold RESET = 0 for 2 cycles with WR = RD = 1.
  - Expect EMPTY = 1, FULL = 0, STATUS = 3'b100, LSTBLK = 0, FRAME_RDY = 0, ERR = 0.
- Fill: 16 writes, no EOF, then 2 extra writes.
  - LSTBLK rises after the 12th write (free = 4).
  - FULL rises after the 16th write, with STATUS = 0.
  - The extra writes leave used = 16.
- Simultaneous at full: WR = RD = 1 for one cycle.
  - Expect FULL = 0, free = 1.
  - The next cycle, WR = RD = 1 keeps used = 15.
- Frame tracking sequence:
  - Write 3 items with WR_EOF on the 3rd: FRAME_RDY = 1 the cycle after the 3rd write.
  - Read 3 items with RD_EOF on the 3rd: FRAME_RDY = 0 and EMPTY = 1 after it.
- Frame underflow: write 2 items without EOF, then read 1 with RD_EOF.
  - Expect ERR = 1, frame count stays 0, used = 1.
  - ERR stays 1 until reset.
- Mid-operation reset: with used = 9 and frame count = 2, pulse RESET = 0 for one cycle.
  - All outputs return to reset values on the next edge.
  - A write on the following cycle gives used = 1.
